window_linebuffer9x9: RTL and testbench

//   Turns a raster-order pixel stream into sliding WIN x WIN windows for the

---
 rtl/window_linebuffer9x9.sv | 125 ++++++++++++
 tb/tb_window_linebuffer9x9.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_linebuffer9x9.sv
// Raster pixel stream to sliding WIN x WIN window, fed by WIN-1 cascaded line buffers.
// Optional WIN_COORD_EN adds win_x/win_y outputs with the window's top-left coordinate.
module window_linebuffer9x9 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int WIN   = 9,
  parameter int PIX_W = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_valid,
  input  logic                       pix_sof,
  input  logic [PIX_W-1:0]           pix_in,
  output logic                       win_valid,
  output logic [WIN*WIN*PIX_W-1:0]   window_flat,
  output logic                       frame_done
`ifdef WIN_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_WIN0 = XW'(WIN - 1);
  localparam logic [YW-1:0] Y_WIN0 = YW'(WIN - 1);

  logic [XW-1:0]    x_cnt;
  logic [YW-1:0]    y_cnt;
  logic [XW-1:0]    cur_x;
  logic [YW-1:0]    cur_y;
  logic             accept;
  logic             win_hit;
  logic             last_pix;

  logic [PIX_W-1:0] lb_mem  [WIN-1][IMG_W];
  logic [PIX_W-1:0] new_col [WIN];
  logic [PIX_W-1:0] win_q   [WIN*WIN];

  // pix_sof overrides the counters so a mid-frame sof restarts at (0,0)
  always_comb begin
    accept   = pix_valid;
    cur_x    = pix_sof ? '0 : x_cnt;
    cur_y    = pix_sof ? '0 : y_cnt;
    win_hit  = (cur_x >= X_WIN0) && (cur_y >= Y_WIN0);
    last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (cur_x == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x_cnt <= cur_x + 1'b1;
        y_cnt <= cur_y;
      end
    end
  end

  // Buffer WIN-2 holds the previous row; each older buffer takes what the younger one held
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < WIN - 2; i++) begin
        lb_mem[i][cur_x] <= lb_mem[i+1][cur_x];
      end
      lb_mem[WIN-2][cur_x] <= pix_in;
    end
  end

  always_comb begin
    for (int i = 0; i < WIN - 1; i++) begin
      new_col[i] = lb_mem[i][cur_x];
    end
    new_col[WIN-1] = pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN * WIN; k++) begin
        win_q[k] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          win_q[r*WIN + c] <= win_q[r*WIN + c + 1];
        end
        win_q[r*WIN + WIN - 1] <= new_col[r];
      end
    end
  end

  for (genvar k = 0; k < WIN * WIN; k++) begin : g_flat
    assign window_flat[PIX_W*k +: PIX_W] = win_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= accept && win_hit;
      frame_done <= accept && last_pix;
    end
  end

`ifdef WIN_COORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x <= '0;
      win_y <= '0;
    end else if (accept && win_hit) begin
      win_x <= cur_x - X_WIN0;
      win_y <= cur_y - Y_WIN0;
    end
  end
`endif

endmodule

// File: tb/tb_window_linebuffer9x9.sv
// Scoreboard bench for window_linebuffer9x9: an image model predicts every cycle's outputs.
// Coordinate outputs are also checked when WIN_COORD_EN is defined.
module tb_window_linebuffer9x9;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int WIN    = 9;
  localparam int PIX_W  = 7;
  localparam int FLAT_W = WIN * WIN * PIX_W;
  localparam int NWIN   = (IMG_W - WIN + 1) * (IMG_H - WIN + 1);
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk;
  logic              rst_n;
  logic              pix_valid;
  logic              pix_sof;
  logic [PIX_W-1:0]  pix_in;
  logic              win_valid;
  logic [FLAT_W-1:0] window_flat;
  logic              frame_done;
`ifdef WIN_COORD_EN
  logic [$clog2(IMG_W)-1:0] win_x;
  logic [$clog2(IMG_H)-1:0] win_y;
`endif

  window_linebuffer9x9 #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .PIX_W(PIX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_in      (pix_in),
    .win_valid   (win_valid),
    .window_flat (window_flat),
    .frame_done  (frame_done)
`ifdef WIN_COORD_EN
    ,
    .win_x       (win_x),
    .win_y       (win_y)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              wv;
    logic              fd;
    logic [FLAT_W-1:0] win;
    int                wx;
    int                wy;
    int                drv_idx;
  } exp_t;

  typedef struct {
    int win_idx;
    int elem;
    int expv;
  } vec_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [FLAT_W-1:0] caps[$];
  logic [FLAT_W-1:0] ref_caps[$];
  logic [PIX_W-1:0]  img [IMG_H][IMG_W];
  vec_t              vecs [10];
  logic [PIX_W-1:0]  elem_val;
  int mx, my;
  int checks, errors;
  int win_count, fd_count, first_idx, fd_idx;

  task automatic checkOutput(input string name, input logic [FLAT_W-1:0] act,
                             input logic [FLAT_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive one cycle of input and queue what the DUT must show one clock later
  task automatic applyStimulus(input logic v, input logic sof, input logic [PIX_W-1:0] p,
                               input int didx);
    exp_t e;
    @(negedge clk);
    pix_valid = v;
    pix_sof   = sof;
    pix_in    = p;
    e.wv = 1'b0; e.fd = 1'b0; e.win = '0; e.wx = 0; e.wy = 0; e.drv_idx = didx;
    if (v) begin
      if (sof) begin mx = 0; my = 0; end
      img[my][mx] = p;
      if (mx >= WIN - 1 && my >= WIN - 1) begin
        e.wv = 1'b1;
        e.wx = mx - WIN + 1;
        e.wy = my - WIN + 1;
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN; c++)
            e.win[PIX_W*(r*WIN + c) +: PIX_W] = img[my-WIN+1+r][mx-WIN+1+c];
      end
      e.fd = (mx == IMG_W - 1) && (my == IMG_H - 1);
      if (mx == IMG_W - 1) begin
        mx = 0;
        my = (my == IMG_H - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic streamPixels(input int count, input int bubble_pct);
    for (int i = 0; i < count; i++) begin
      while (bubble_pct > 0 && $urandom_range(99) < bubble_pct)
        applyStimulus(1'b0, 1'b0, PIX_W'($urandom), -1);
      applyStimulus(1'b1, i == 0, PIX_W'(i % 128), i);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, '0, -1);
  endtask

  task automatic startPhase();
    win_count = 0;
    fd_count  = 0;
    first_idx = -1;
    fd_idx    = -1;
    caps.delete();
  endtask

  task automatic checkCaptures(input string name);
    checkOutput({name, "_count"}, FLAT_W'(caps.size()), FLAT_W'(ref_caps.size()));
    for (int i = 0; i < caps.size() && i < ref_caps.size(); i++)
      checkOutput({name, "_window"}, caps[i], ref_caps[i]);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("win_valid", FLAT_W'(win_valid), FLAT_W'(mon_e.wv));
      checkOutput("frame_done", FLAT_W'(frame_done), FLAT_W'(mon_e.fd));
      if (mon_e.wv) begin
        checkOutput("window_flat", window_flat, mon_e.win);
`ifdef WIN_COORD_EN
        checkOutput("win_x", FLAT_W'(win_x), FLAT_W'(mon_e.wx));
        checkOutput("win_y", FLAT_W'(win_y), FLAT_W'(mon_e.wy));
`endif
      end
      if (win_valid) begin
        win_count++;
        caps.push_back(window_flat);
        if (first_idx < 0) first_idx = mon_e.drv_idx;
      end
      if (frame_done) begin
        fd_count++;
        fd_idx = mon_e.drv_idx;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // {window index, element, expected pixel} for pix=(y*28+x)%128
    vecs[0] = '{0, 0, 0};     vecs[1] = '{0, 8, 8};     vecs[2] = '{0, 80, 104};
    vecs[3] = '{1, 0, 1};     vecs[4] = '{1, 80, 105};  vecs[5] = '{20, 0, 28};
    vecs[6] = '{20, 80, 4};   vecs[7] = '{399, 0, 39};  vecs[8] = '{399, 8, 47};
    vecs[9] = '{399, 80, 15};

    checks = 0; errors = 0; mx = 0; my = 0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0;
    startPhase();

    // Power-on reset, checked before any clock edge
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_win_valid", FLAT_W'(win_valid), '0);
    checkOutput("reset_frame_done", FLAT_W'(frame_done), '0);
    checkOutput("reset_window_flat", window_flat, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] full frame, continuous");
    startPhase();
    streamPixels(NPIX, 0);
    checkOutput("t2_win_count", FLAT_W'(win_count), FLAT_W'(NWIN));
    checkOutput("t2_fd_count", FLAT_W'(fd_count), FLAT_W'(1));
    checkOutput("t2_first_idx", FLAT_W'(first_idx), FLAT_W'(232));
    checkOutput("t2_fd_idx", FLAT_W'(fd_idx), FLAT_W'(783));
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].win_idx < caps.size()) begin
        elem_val = caps[vecs[i].win_idx][PIX_W*vecs[i].elem +: PIX_W];
        checkOutput($sformatf("vec%0d_w%0d_e%0d", i, vecs[i].win_idx, vecs[i].elem),
                    FLAT_W'(elem_val), FLAT_W'(vecs[i].expv));
      end else begin
        checkOutput($sformatf("vec%0d_missing_window", i), FLAT_W'(caps.size()),
                    FLAT_W'(vecs[i].win_idx + 1));
      end
    end
    ref_caps = caps;

    $display("[TB] full frame with bubbles");
    startPhase();
    streamPixels(NPIX, 30);
    checkOutput("t3_fd_count", FLAT_W'(fd_count), FLAT_W'(1));
    checkCaptures("t3");

    $display("[TB] sof restart at pixel 100");
    startPhase();
    streamPixels(100, 0);
    streamPixels(NPIX, 0);
    checkOutput("t4_fd_count", FLAT_W'(fd_count), FLAT_W'(1));
    checkOutput("t4_first_idx", FLAT_W'(first_idx), FLAT_W'(232));
    checkCaptures("t4");

    $display("[TB] reset mid-frame at pixel 300");
    startPhase();
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b1, i == 0, PIX_W'(i % 128), i);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    pix_valid = 1'b0;
    exp_q.delete();
    mx = 0; my = 0;
    #1;
    checkOutput("t5_rst_win_valid", FLAT_W'(win_valid), '0);
    checkOutput("t5_rst_frame_done", FLAT_W'(frame_done), '0);
    checkOutput("t5_rst_window_flat", window_flat, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    startPhase();
    streamPixels(NPIX, 0);
    checkOutput("t5_fd_count", FLAT_W'(fd_count), FLAT_W'(1));
    checkCaptures("t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
